// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : Valid/ready fed asynchronous serial transmitter: start bit,
//                LSB-first data, optional even parity (UART_TX_PARITY_EN),
//                one stop bit. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 async_reset_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_PERIOD_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_STOP_LAST   = c_CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST    = c_BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t               r_state;
    state_t               w_state_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [c_BIT_W-1:0]   w_bit_cnt_next;
    logic [c_CNT_W-1:0]   r_period_cnt;
    logic [c_CNT_W-1:0]   w_period_next;
    logic                 w_period_done;
    logic                 w_serial_next;
    logic                 w_ready_next;
    logic                 w_busy_next;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
    logic                 w_parity_next;
`endif

    assign w_period_done = (r_period_cnt == c_PERIOD_LAST);

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_period_cnt <= '0;
            tx_serial    <= 1'b1;
            tx_ready     <= 1'b1;
            tx_busy      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_period_cnt <= w_period_next;
            tx_serial    <= w_serial_next;
            tx_ready     <= w_ready_next;
            tx_busy      <= w_busy_next;
`ifdef UART_TX_PARITY_EN
            r_parity     <= w_parity_next;
`endif
        end
    end

    // The final stop-bit cycle is spent in IDLE so a waiting word is taken on
    // the frame boundary edge, giving gapless back-to-back frames.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_period_next  = w_period_done ? '0 : r_period_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
        w_parity_next  = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_period_next = '0;
                if (tx_valid && tx_ready) begin
                    w_state_next   = START;
                    w_shift_next   = tx_data;
                    w_bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                    w_parity_next  = ^tx_data;
`endif
                end
            end
            START: begin
                if (w_period_done) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_period_done) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == c_BIT_LAST) begin
                        w_bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next   = PARITY;
`else
                        w_state_next   = STOP;
`endif
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_period_done) begin
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (r_period_cnt == c_STOP_LAST) begin
                    w_state_next  = IDLE;
                    w_period_next = '0;
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_period_next = '0;
            end
        endcase
    end

    always_comb begin
        w_serial_next = 1'b1;
        case (w_state_next)
            START:   w_serial_next = 1'b0;
            DATA:    w_serial_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_serial_next = r_parity;
`endif
            default: w_serial_next = 1'b1;
        endcase
        w_ready_next = (w_state_next == IDLE);
        w_busy_next  = (w_state_next != IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Directed self-checking bench for uart_tx (CLKS_PER_BIT=4,
//                DATA_BITS=8); parity cases follow UART_TX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int C  = 4;
    localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DB + 3;
`else
    localparam int NB = DB + 2;
`endif
    localparam int F = NB * C;

    logic          clk;
    logic          async_reset_n;
    logic          tx_valid;
    logic [DB-1:0] tx_data;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_busy;

    int checks   = 0;
    int failures = 0;

    uart_tx #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (DB)
    ) dut (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .tx_serial     (tx_serial),
        .tx_busy       (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line value per bit slot: start, LSB-first data, [parity], stop.
    function automatic logic [11:0] exp_frame(input logic [DB-1:0] d);
        logic [11:0] f;
        f = '0;
        f[0] = 1'b0;
        for (int i = 0; i < DB; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        f[DB+1] = ^d;
`endif
        f[NB-1] = 1'b1;
        return f;
    endfunction

    task automatic handshake(input logic [DB-1:0] d, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: tx_ready=%b, required 1", tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    // Observes one frame of F cycles starting right after the handshake edge.
    task automatic run_frame(output logic [11:0] obs, output bit stable,
                             output int gap, output logic busy_end,
                             input int pulse_at);
        int j;
        obs = '0;
        stable = 1'b1;
        gap = 0;
        busy_end = 1'bx;
        for (int i = 0; i < F; i++) begin
            @(negedge clk);
            j = i / C;
            if (i % C == 0) obs[j] = tx_serial;
            else if (tx_serial !== obs[j]) stable = 1'b0;
            if (gap == 0 && tx_ready === 1'b1) gap = i + 1;
            busy_end = tx_busy;
            if (i == pulse_at) tx_valid = 1'b1;
            else if (i == pulse_at + 1) tx_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        tx_valid      = 1'b0;
        tx_data       = '0;
        async_reset_n = 1'b1;
        #2;
        async_reset_n = 1'b0;
        #1;
        checks++;
        if (tx_serial !== 1'b1) begin failures++; $display("FAIL reset_serial: got %b, required 1", tx_serial); end
        checks++;
        if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b, required 1", tx_ready); end
        checks++;
        if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        async_reset_n = 1'b1;
    endtask

    task automatic test_single_frame;
        logic [11:0] obs;
        bit          stable;
        int          gap;
        logic        busy_end;
        handshake(8'hA5, 1'b0);
        run_frame(obs, stable, gap, busy_end, -10);
        checks++;
        if (obs !== exp_frame(8'hA5)) begin failures++; $display("FAIL a5_bits: got %h, required %h", obs, exp_frame(8'hA5)); end
        checks++;
        if (!stable) begin failures++; $display("FAIL a5_bit_hold: got unstable bit, required each bit held %0d cycles", C); end
        checks++;
        if (gap != F) begin failures++; $display("FAIL a5_ready_gap: got %0d, required %0d", gap, F); end
        checks++;
        if (busy_end !== 1'b0) begin failures++; $display("FAIL a5_busy_end: got %b, required 0", busy_end); end
    endtask

    task automatic test_capture_and_ignore;
        logic [11:0] obs;
        bit          stable;
        int          gap;
        logic        busy_end;
        int          quiet_bad;
        handshake(8'h3C, 1'b0);
        tx_data = 8'hFF;
        run_frame(obs, stable, gap, busy_end, 10);
        checks++;
        if (obs !== exp_frame(8'h3C)) begin failures++; $display("FAIL capture_bits: got %h, required %h", obs, exp_frame(8'h3C)); end
        checks++;
        if (!stable) begin failures++; $display("FAIL capture_bit_hold: got unstable bit, required stable"); end
        quiet_bad = 0;
        repeat (3 * C) begin
            @(negedge clk);
            if (tx_busy !== 1'b0 || tx_serial !== 1'b1 || tx_ready !== 1'b1) quiet_bad++;
        end
        checks++;
        if (quiet_bad != 0) begin failures++; $display("FAIL ignored_valid: got %0d active cycles after frame, required 0", quiet_bad); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] obs1;
        logic [11:0] obs2;
        bit          stable1;
        bit          stable2;
        int          gap1;
        int          gap2;
        logic        busy1;
        logic        busy2;
        handshake(8'h00, 1'b1);
        tx_data = 8'hFF;
        run_frame(obs1, stable1, gap1, busy1, -10);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        run_frame(obs2, stable2, gap2, busy2, -10);
        checks++;
        if (obs1 !== exp_frame(8'h00)) begin failures++; $display("FAIL b2b_first_bits: got %h, required %h", obs1, exp_frame(8'h00)); end
        checks++;
        if (gap1 != F) begin failures++; $display("FAIL b2b_handshake_cycle: got %0d, required %0d", gap1, F); end
        checks++;
        if (obs2 !== exp_frame(8'hFF)) begin failures++; $display("FAIL b2b_second_bits: got %h, required %h", obs2, exp_frame(8'hFF)); end
        checks++;
        if (!stable2) begin failures++; $display("FAIL b2b_second_hold: got unstable bit, required stable"); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [11:0] obs;
        bit          stable;
        int          gap;
        logic        busy_end;
        handshake(8'hA5, 1'b0);
        run_frame(obs, stable, gap, busy_end, -10);
        checks++;
        if (obs[DB+1] !== 1'b0) begin failures++; $display("FAIL parity_a5: got %b, required 0", obs[DB+1]); end
        checks++;
        if (gap != 44) begin failures++; $display("FAIL parity_frame_len: got %0d, required 44", gap); end
        handshake(8'h07, 1'b0);
        run_frame(obs, stable, gap, busy_end, -10);
        checks++;
        if (obs[DB+1] !== 1'b1) begin failures++; $display("FAIL parity_07: got %b, required 1", obs[DB+1]); end
        checks++;
        if (obs !== exp_frame(8'h07)) begin failures++; $display("FAIL parity_07_bits: got %h, required %h", obs, exp_frame(8'h07)); end
    endtask
`endif

    task automatic test_reset_midframe;
        logic [11:0] obs;
        bit          stable;
        int          gap;
        logic        busy_end;
        handshake(8'h55, 1'b0);
        repeat (4 * C + 2) @(negedge clk);
        checks++;
        if (tx_serial !== 1'b0 || tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_data_bit3: got serial=%b busy=%b, required serial=0 busy=1", tx_serial, tx_busy);
        end
        #1;
        async_reset_n = 1'b0;
        #1;
        checks++;
        if (tx_serial !== 1'b1) begin failures++; $display("FAIL mid_reset_serial: got %b, required 1", tx_serial); end
        checks++;
        if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_flags: got ready=%b busy=%b, required ready=1 busy=0", tx_ready, tx_busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        async_reset_n = 1'b1;
        handshake(8'h81, 1'b0);
        run_frame(obs, stable, gap, busy_end, -10);
        checks++;
        if (obs !== exp_frame(8'h81)) begin failures++; $display("FAIL post_reset_bits: got %h, required %h", obs, exp_frame(8'h81)); end
        checks++;
        if (gap != F || !stable) begin failures++; $display("FAIL post_reset_timing: got gap=%0d stable=%0d, required gap=%0d stable=1", gap, stable, F); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_capture_and_ignore();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
